// File: rtl/cu_readback_pkg.sv
// -----------------------------------------------------------------------------
// cu_readback_pkg
//
// Shared definitions for the memory-B drain side. The default buffer geometry
// is also used by the write-side control unit, so both ends agree on the
// number of words and the address/data widths.
//
// Contents:
//   DEFAULT_DEPTH  - words drained per run
//   DEFAULT_ADDR_W - memory B address width
//   DEFAULT_DATA_W - memory B / output data width
//   state_t        - readback FSM state encoding
// -----------------------------------------------------------------------------
package cu_readback_pkg;

    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_ADDR_W = 3;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage : cu_readback_pkg

// File: rtl/cu_readback_rd_addr_counter.sv
// -----------------------------------------------------------------------------
// rd_addr_counter
//
// Read-address counter for memory B. Synchronous clear has priority over
// increment. The increment wraps modulo 2**ADDR_W; the controller never
// increments past the terminal count, so the wrap is not reachable in use.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset (count -> 0)
//   clear in   synchronous clear (count -> 0)
//   inc   in   increment enable
//   count out  current address
//   tc    out  terminal count, high when count == DEPTH-1
// -----------------------------------------------------------------------------
module rd_addr_counter #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == ADDR_W'(DEPTH - 1));

endmodule : rd_addr_counter

// File: rtl/cu_readback.sv
// -----------------------------------------------------------------------------
// cu_readback
//
// Drains DEPTH words from memory B, starting at address 0, onto a valid/ready
// stream. Each word takes three states: FETCH drives the read enable, LATCH
// captures the memory data one cycle later, PRESENT holds the word until the
// consumer accepts it. After the last word is accepted, DONE pulses for one
// cycle and the block returns to IDLE.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset, aborts any run in progress
//   start     in   begin a drain run (only looked at in IDLE)
//   REB       out  memory B read enable (high in FETCH)
//   rd_addr   out  memory B read address
//   dout_b    in   memory B read data, valid the cycle after REB
//   out_data  out  registered output word
//   out_valid out  out_data holds an unconsumed word
//   out_ready in   consumer accepts when out_valid & out_ready
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module cu_readback
    import cu_readback_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              REB,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] dout_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t state;
    state_t next_state;

    logic   cnt_clear;
    logic   cnt_inc;
    logic   last_word;
    logic   accept;

    // Consumer handshake completes only while a word is being presented.
    assign accept = (state == ST_PRESENT) && out_ready;

    rd_addr_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_addr_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (rd_addr),
        .tc    (last_word)
    );

    // Address restarts at 0 both when a run is launched and when it ends;
    // it advances only on acceptance of a word that is not the last one.
    assign cnt_clear = ((state == ST_IDLE) && start) || (state == ST_DONE);
    assign cnt_inc   = accept && !last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so every path assigns
    // it; a missing branch would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (start) next_state = ST_FETCH;
            ST_FETCH:   next_state = ST_LATCH;
            ST_LATCH:   next_state = ST_PRESENT;
            ST_PRESENT: if (out_ready) next_state = last_word ? ST_DONE : ST_FETCH;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Output word register. out_data is only reloaded in LATCH, so it stays
    // stable for the whole PRESENT stall regardless of what memory B drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (state == ST_LATCH) begin
            out_data  <= dout_b;
            out_valid <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

    assign REB  = (state == ST_FETCH);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule : cu_readback

// File: tb/tb_cu_readback.sv
// -----------------------------------------------------------------------------
// tb_cu_readback
//
// Self-checking bench for cu_readback. A behavioural memory B returns
// mem[rd_addr] the cycle after REB. A cycle-by-cycle vector table covers
// reset, idle and the opening of a run; scripted runs cover full drains,
// backpressure, start while busy, reset mid-run and back-to-back runs, with
// every accepted word compared against a queue of expected words.
// -----------------------------------------------------------------------------
module tb_cu_readback;
    import cu_readback_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              reb;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] dout_b = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    cu_readback #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .REB       (reb),
        .rd_addr   (rd_addr),
        .dout_b    (dout_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Memory B model: synchronous read, data valid the cycle after REB.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (reb) dout_b <= mem[rd_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected words queued per run, popped on each handshake.
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] sb_exp;
    bit                sb_on = 1'b0;

    always @(negedge clk) begin
        if (sb_on && !rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                check("sb_word", 32'(out_data), 32'(sb_exp));
            end
        end
    end

    task automatic push_runs(input int nruns);
        for (int r = 0; r < nruns; r++)
            for (int i = 0; i < DEPTH; i++) sb.push_back(mem[i]);
    endtask

    // Cycle-by-cycle vectors: inputs are sampled at an edge, expected
    // outputs are those right after that edge.
    typedef struct {
        logic              rst;
        logic              start;
        logic              ready;
        logic              reb;
        logic              valid;
        logic              busy;
        logic              done;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vt [NVEC];

    // Per-run observations, cycle c being the interval before edge c.
    int   r_first_reb, r_first_valid, r_n_done, r_first_done, r_last_done;
    int   r_n_acc, r_last_acc, r_n_reb, r_viol, r_hold, r_stall_reb, r_reb2;
    logic r_busy_after, r_post_valid, r_post_busy, r_post_reb;
    logic [ADDR_W-1:0] r_post_addr;

    task automatic run(input int ncyc, input int stall_lo, input int stall_hi,
                       input int start_last, input int xs1, input int xs2,
                       input int rst_cyc, input logic [DATA_W-1:0] hold_exp);
        logic [ADDR_W-1:0] prev_addr;
        bit                prev_skip;
        r_first_reb = -1; r_first_valid = -1; r_n_done = 0; r_first_done = -1;
        r_last_done = -1; r_n_acc = 0; r_last_acc = -1; r_n_reb = 0; r_viol = 0;
        r_hold = 0; r_stall_reb = 0; r_reb2 = -1; r_busy_after = 1'bx;
        r_post_valid = 1'bx; r_post_busy = 1'bx; r_post_reb = 1'bx; r_post_addr = 'x;
        rst       = 1'b0;
        start     = (start_last >= 0);
        out_ready = 1'b1;
        prev_addr = rd_addr;
        prev_skip = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #2;
            start     = (c <= start_last) || (c == xs1) || (c == xs2);
            rst       = (c == rst_cyc);
            out_ready = !(c >= stall_lo && c <= stall_hi);
            @(negedge clk);
            if (reb) r_n_reb++;
            if (reb && r_first_reb < 0) r_first_reb = c;
            if (reb && r_first_done >= 0 && r_reb2 < 0) r_reb2 = c;
            if (out_valid && r_first_valid < 0) r_first_valid = c;
            if (r_first_done >= 0 && c == r_first_done + 1) r_busy_after = busy;
            if (done) begin
                r_n_done++;
                if (r_first_done < 0) r_first_done = c;
                r_last_done = c;
            end
            if (out_valid && out_ready && !rst) begin
                r_n_acc++;
                r_last_acc = c;
            end
            if (c >= stall_lo && c <= stall_hi) begin
                if (out_valid && out_data == hold_exp) r_hold++;
                if (reb) r_stall_reb++;
            end
            if (c == rst_cyc + 1) begin
                r_post_valid = out_valid;
                r_post_busy  = busy;
                r_post_reb   = reb;
                r_post_addr  = rd_addr;
            end
            if (done && out_valid) r_viol++;
            if (reb && out_valid) r_viol++;
            if (rd_addr > ADDR_W'(DEPTH - 1)) r_viol++;
            if (!prev_skip && rd_addr < prev_addr) r_viol++;
            prev_skip = done || rst;
            prev_addr = rd_addr;
        end
        @(posedge clk); #2;
        start     = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(8'h10 + i);

        //            rst   start ready  reb   valid busy  done  addr  data
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        for (int i = 2; i <= 6; i++)
            vt[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h10};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h10};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h10};
        vt[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h10};
        vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h10};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h11};
        vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};

        // Reset, idle, opening of a run with a stall, reset mid-run.
        for (int i = 0; i < NVEC; i++) begin
            rst       = vt[i].rst;
            start     = vt[i].start;
            out_ready = vt[i].ready;
            @(posedge clk); #1;
            check($sformatf("vec%0d_reb", i),   32'(reb),       32'(vt[i].reb));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].valid));
            check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vt[i].busy));
            check($sformatf("vec%0d_done", i),  32'(done),      32'(vt[i].done));
            check($sformatf("vec%0d_addr", i),  32'(rd_addr),   32'(vt[i].addr));
            check($sformatf("vec%0d_data", i),  32'(out_data),  32'(vt[i].data));
        end
        sb_on = 1'b1;

        // Full drain, no stall.
        push_runs(1);
        run(30, -1, -2, 0, -1, -1, -1, 8'h00);
        check("drain_first_reb",   32'(r_first_reb),   32'd1);
        check("drain_first_valid", 32'(r_first_valid), 32'd3);
        check("drain_n_acc",       32'(r_n_acc),       32'd8);
        check("drain_last_acc",    32'(r_last_acc),    32'd24);
        check("drain_n_reb",       32'(r_n_reb),       32'd8);
        check("drain_n_done",      32'(r_n_done),      32'd1);
        check("drain_done_cycle",  32'(r_first_done),  32'd25);
        check("drain_busy_after",  32'(r_busy_after),  32'd0);
        check("drain_invariants",  32'(r_viol),        32'd0);
        check("drain_sb_empty",    32'(sb.size()),     32'd0);

        // Backpressure on word 2 for four cycles.
        push_runs(1);
        run(34, 9, 12, 0, -1, -1, -1, mem[2]);
        check("bp_hold_cycles",    32'(r_hold),        32'd4);
        check("bp_reb_in_stall",   32'(r_stall_reb),   32'd0);
        check("bp_n_acc",          32'(r_n_acc),       32'd8);
        check("bp_last_acc",       32'(r_last_acc),    32'd28);
        check("bp_n_reb",          32'(r_n_reb),       32'd8);
        check("bp_done_cycle",     32'(r_first_done),  32'd29);
        check("bp_n_done",         32'(r_n_done),      32'd1);
        check("bp_invariants",     32'(r_viol),        32'd0);
        check("bp_sb_empty",       32'(sb.size()),     32'd0);

        // Extra start pulses while busy are ignored.
        push_runs(1);
        run(30, -1, -2, 0, 5, 12, -1, 8'h00);
        check("sb_busy_n_acc",     32'(r_n_acc),       32'd8);
        check("sb_busy_n_done",    32'(r_n_done),      32'd1);
        check("sb_busy_done_cyc",  32'(r_first_done),  32'd25);
        check("sb_busy_n_reb",     32'(r_n_reb),       32'd8);
        check("sb_busy_invar",     32'(r_viol),        32'd0);
        check("sb_busy_sb_empty",  32'(sb.size()),     32'd0);

        // Reset while a word is presented, then a clean drain from address 0.
        push_runs(1);
        run(12, 9, 11, 0, -1, -1, 10, mem[2]);
        check("rstmid_n_acc",      32'(r_n_acc),       32'd2);
        check("rstmid_valid_held", 32'(r_hold),        32'd2);
        check("rstmid_n_done",     32'(r_n_done),      32'd0);
        check("rstmid_post_valid", 32'(r_post_valid),  32'd0);
        check("rstmid_post_busy",  32'(r_post_busy),   32'd0);
        check("rstmid_post_reb",   32'(r_post_reb),    32'd0);
        check("rstmid_post_addr",  32'(r_post_addr),   32'd0);
        check("rstmid_sb_left",    32'(sb.size()),     32'd6);
        sb.delete();
        push_runs(1);
        run(30, -1, -2, 0, -1, -1, -1, 8'h00);
        check("rerun_n_acc",       32'(r_n_acc),       32'd8);
        check("rerun_done_cycle",  32'(r_first_done),  32'd25);
        check("rerun_sb_empty",    32'(sb.size()),     32'd0);

        // start held high across two runs.
        push_runs(2);
        run(56, -1, -2, 50, -1, -1, -1, 8'h00);
        check("b2b_n_done",        32'(r_n_done),      32'd2);
        check("b2b_first_done",    32'(r_first_done),  32'd25);
        check("b2b_second_reb",    32'(r_reb2),        32'd27);
        check("b2b_last_done",     32'(r_last_done),   32'd51);
        check("b2b_n_acc",         32'(r_n_acc),       32'd16);
        check("b2b_invariants",    32'(r_viol),        32'd0);
        check("b2b_sb_empty",      32'(sb.size()),     32'd0);
        check("b2b_idle_after",    32'(busy),          32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cu_readback
